// File: rtl/alu_action_responder_if.sv
// Handshake bundle between an ALU action producer (master) and the
// staging/execute responder (slave).
interface alu_action_responder_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  i_OpValid;
  logic [2:0]            i_OpCode;
  logic                  o_OpAccept;
  logic                  i_DataValid;
  logic [DATA_WIDTH-1:0] i_DataA;
  logic [DATA_WIDTH-1:0] i_DataB;
  logic                  o_DataAccept;
  logic                  o_ALUOpReady;
  logic                  o_DataReady;
  logic                  i_Action;
  logic [DATA_WIDTH-1:0] o_Result;
  logic                  o_Zero;
  logic                  o_Carry;
  logic                  o_ResultValid;
  logic                  i_ResultAck;
  logic                  o_Timeout;

  modport slave (
    input  i_OpValid, i_OpCode, i_DataValid, i_DataA, i_DataB, i_Action, i_ResultAck,
    output o_OpAccept, o_DataAccept, o_ALUOpReady, o_DataReady,
           o_Result, o_Zero, o_Carry, o_ResultValid, o_Timeout
  );

  modport master (
    output i_OpValid, i_OpCode, i_DataValid, i_DataA, i_DataB, i_Action, i_ResultAck,
    input  o_OpAccept, o_DataAccept, o_ALUOpReady, o_DataReady,
           o_Result, o_Zero, o_Carry, o_ResultValid, o_Timeout
  );
endinterface

// File: rtl/alu_action_responder.sv
// Collects opcode and operands in any order, waits for an action strobe,
// executes one ALU operation and holds the result until acknowledged.
module alu_action_responder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ACTION_TIMEOUT = 15
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  alu_action_responder_if.slave bus
);

  localparam int CW = (ACTION_TIMEOUT < 2) ? 1 : $clog2(ACTION_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(ACTION_TIMEOUT - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ARMED   = 2'd1,
    EXEC    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  op_rdy_q, op_rdy_d;
  logic                  data_rdy_q, data_rdy_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  carry_q, carry_d;
  logic                  rv_q, rv_d;
  logic                  timeout_q, timeout_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   alu_s;
  logic                  op_take_s, data_take_s;

  // Top bit of the returned vector is carry / borrow / shifted-out bit.
  function automatic logic [DATA_WIDTH:0] alu_compute(
    input logic [2:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] r;
    r = '0;
    case (op)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = {1'b0, ~a};
      3'd6:    r = {a, 1'b0};
      3'd7:    r = {a[0], 1'b0, a[DATA_WIDTH-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign bus.o_OpAccept    = (state_q == COLLECT) && !op_rdy_q;
  assign bus.o_DataAccept  = (state_q == COLLECT) && !data_rdy_q;
  assign bus.o_ALUOpReady  = op_rdy_q;
  assign bus.o_DataReady   = data_rdy_q;
  assign bus.o_Result      = result_q;
  assign bus.o_Zero        = zero_q;
  assign bus.o_Carry       = carry_q;
  assign bus.o_ResultValid = rv_q;
  assign bus.o_Timeout     = timeout_q;

  assign op_take_s   = bus.i_OpValid   && bus.o_OpAccept;
  assign data_take_s = bus.i_DataValid && bus.o_DataAccept;
  assign alu_s       = alu_compute(op_q, a_q, b_q);

  // Next-state and datapath update for the collect/arm/execute/hold sequence.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    op_rdy_d   = op_rdy_q;
    data_rdy_d = data_rdy_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    rv_d       = rv_q;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;

    case (state_q)
      COLLECT: begin
        if (op_take_s) begin
          op_d     = bus.i_OpCode;
          op_rdy_d = 1'b1;
        end else begin
          op_d     = op_q;
        end
        if (data_take_s) begin
          a_d        = bus.i_DataA;
          b_d        = bus.i_DataB;
          data_rdy_d = 1'b1;
        end else begin
          a_d        = a_q;
        end
        if (op_rdy_d && data_rdy_d) begin
          state_d = ARMED;
          cnt_d   = '0;
        end else begin
          state_d = COLLECT;
        end
      end

      ARMED: begin
        if (bus.i_Action) begin
          state_d    = EXEC;
          op_rdy_d   = 1'b0;
          data_rdy_d = 1'b0;
        end else if (cnt_q == TMO_LAST) begin
          // Abandon the armed operation; the slot reopens on the next cycle.
          state_d    = COLLECT;
          op_rdy_d   = 1'b0;
          data_rdy_d = 1'b0;
          timeout_d  = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d      = cnt_q + CW'(1);
        end
      end

      EXEC: begin
        result_d = alu_s[DATA_WIDTH-1:0];
        carry_d  = alu_s[DATA_WIDTH];
        zero_d   = (alu_s[DATA_WIDTH-1:0] == '0);
        rv_d     = 1'b1;
        state_d  = DONE;
      end

      DONE: begin
        if (bus.i_ResultAck) begin
          rv_d    = 1'b0;
          state_d = COLLECT;
        end else begin
          rv_d    = 1'b1;
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q    <= COLLECT;
      op_q       <= 3'd0;
      a_q        <= '0;
      b_q        <= '0;
      op_rdy_q   <= 1'b0;
      data_rdy_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      rv_q       <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_rdy_q   <= op_rdy_d;
      data_rdy_q <= data_rdy_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      rv_q       <= rv_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_action_responder.sv
// Self-checking bench for alu_action_responder: directed scenarios plus
// randomized operations checked against an arithmetic reference model.
module tb_alu_action_responder;

  localparam int DW  = 8;
  localparam int TMO = 15;

  // Status vector: {OpAccept, DataAccept, ALUOpReady, DataReady, ResultValid, Timeout}
  localparam logic [5:0] S_IDLE   = 6'b110000;
  localparam logic [5:0] S_ARMED  = 6'b001100;
  localparam logic [5:0] S_EXEC   = 6'b000000;
  localparam logic [5:0] S_DONE   = 6'b000010;
  localparam logic [5:0] S_TMO    = 6'b110001;
  localparam logic [5:0] S_OPONLY = 6'b011000;
  localparam logic [5:0] S_DTONLY = 6'b100100;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_action_responder_if #(.DATA_WIDTH(DW)) ifc ();

  alu_action_responder #(.DATA_WIDTH(DW), .ACTION_TIMEOUT(TMO)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] status();
    return {ifc.o_OpAccept, ifc.o_DataAccept, ifc.o_ALUOpReady,
            ifc.o_DataReady, ifc.o_ResultValid, ifc.o_Timeout};
  endfunction

  function automatic logic [9:0] res_vec();
    return {ifc.o_Result, ifc.o_Zero, ifc.o_Carry};
  endfunction

  // Reference model: returns {result, zero, carry} from plain integer arithmetic.
  function automatic logic [9:0] ref_alu(input int op, input int a, input int b);
    int r;
    int c;
    r = 0;
    c = 0;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
      7: begin r = a / 2; c = a % 2; end
      default: r = 0;
    endcase
    return {r[7:0], (r == 0) ? 1'b1 : 1'b0, c[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input int op, input int a, input int b);
    ifc.i_OpValid   = 1'b1;
    ifc.i_OpCode    = op[2:0];
    ifc.i_DataValid = 1'b1;
    ifc.i_DataA     = a[7:0];
    ifc.i_DataB     = b[7:0];
    tick();
    ifc.i_OpValid   = 1'b0;
    ifc.i_DataValid = 1'b0;
  endtask

  task automatic fire();
    ifc.i_Action = 1'b1;
    tick();
    ifc.i_Action = 1'b0;
    tick();
  endtask

  task automatic ack();
    ifc.i_ResultAck = 1'b1;
    tick();
    ifc.i_ResultAck = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.i_OpValid = 1'b1; ifc.i_DataValid = 1'b1; ifc.i_Action = 1'b1;
    tick();
    tick();
    n_checks++;
    if (status() !== S_IDLE) begin
      n_errors++; $display("FAIL reset_status got=%b exp=%b", status(), S_IDLE);
    end
    n_checks++;
    if (res_vec() !== 10'd0) begin
      n_errors++; $display("FAIL reset_result got=%h exp=%h", res_vec(), 10'd0);
    end
    ifc.i_OpValid = 1'b0; ifc.i_DataValid = 1'b0; ifc.i_Action = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_same_cycle();
    arm(0, 8'hF0, 8'h20);
    n_checks++;
    if (status() !== S_ARMED) begin
      n_errors++; $display("FAIL add_armed got=%b exp=%b", status(), S_ARMED);
    end
    ifc.i_Action = 1'b1;
    tick();
    ifc.i_Action = 1'b0;
    n_checks++;
    if (status() !== S_EXEC) begin
      n_errors++; $display("FAIL add_exec got=%b exp=%b", status(), S_EXEC);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (status() !== S_DONE || res_vec() !== {8'h10, 1'b0, 1'b1}) begin
        n_errors++; $display("FAIL add_hold[%0d] st=%b res=%h exp_res=%h", i, status(), res_vec(), {8'h10, 1'b0, 1'b1});
      end
      tick();
    end
    ack();
    n_checks++;
    if (status() !== S_IDLE || res_vec() !== {8'h10, 1'b0, 1'b1}) begin
      n_errors++; $display("FAIL add_after_ack st=%b res=%h", status(), res_vec());
    end
  endtask

  task automatic test_data_first();
    ifc.i_DataValid = 1'b1; ifc.i_DataA = 8'h55; ifc.i_DataB = 8'h55;
    tick();
    ifc.i_DataValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (status() !== S_DTONLY) begin
        n_errors++; $display("FAIL data_first_wait[%0d] got=%b exp=%b", i, status(), S_DTONLY);
      end
      if (i < 2) tick();
    end
    ifc.i_OpValid = 1'b1; ifc.i_OpCode = 3'd1;
    tick();
    ifc.i_OpValid = 1'b0;
    n_checks++;
    if (status() !== S_ARMED) begin
      n_errors++; $display("FAIL data_first_armed got=%b exp=%b", status(), S_ARMED);
    end
    fire();
    n_checks++;
    if (status() !== S_DONE || res_vec() !== {8'h00, 1'b1, 1'b0}) begin
      n_errors++; $display("FAIL sub_zero st=%b res=%h exp=%h", status(), res_vec(), {8'h00, 1'b1, 1'b0});
    end
    ack();
  endtask

  task automatic test_timeout();
    arm(4, 8'h3C, 8'h0F);
    for (int i = 1; i < TMO; i++) begin
      tick();
      n_checks++;
      if (status() !== S_ARMED) begin
        n_errors++; $display("FAIL tmo_wait[%0d] got=%b exp=%b", i, status(), S_ARMED);
      end
    end
    tick();
    n_checks++;
    if (status() !== S_TMO) begin
      n_errors++; $display("FAIL tmo_pulse got=%b exp=%b", status(), S_TMO);
    end
    tick();
    n_checks++;
    if (status() !== S_IDLE) begin
      n_errors++; $display("FAIL tmo_pulse_end got=%b exp=%b", status(), S_IDLE);
    end
    ifc.i_OpValid = 1'b1; ifc.i_OpCode = 3'd3;
    tick();
    ifc.i_OpValid = 1'b0;
    n_checks++;
    if (status() !== S_OPONLY) begin
      n_errors++; $display("FAIL tmo_next_accept got=%b exp=%b", status(), S_OPONLY);
    end
    ifc.i_DataValid = 1'b1; ifc.i_DataA = 8'hA0; ifc.i_DataB = 8'h05;
    tick();
    ifc.i_DataValid = 1'b0;
    fire();
    n_checks++;
    if (res_vec() !== ref_alu(3, 8'hA0, 8'h05)) begin
      n_errors++; $display("FAIL tmo_followup got=%h exp=%h", res_vec(), ref_alu(3, 8'hA0, 8'h05));
    end
    ack();
  endtask

  task automatic test_action_vs_timeout();
    arm(2, 8'hCC, 8'hAA);
    for (int i = 1; i < TMO; i++) tick();
    ifc.i_Action = 1'b1;
    tick();
    ifc.i_Action = 1'b0;
    n_checks++;
    if (status() !== S_EXEC) begin
      n_errors++; $display("FAIL action_wins got=%b exp=%b", status(), S_EXEC);
    end
    tick();
    n_checks++;
    if (status() !== S_DONE || res_vec() !== ref_alu(2, 8'hCC, 8'hAA)) begin
      n_errors++; $display("FAIL action_wins_res st=%b res=%h exp=%h", status(), res_vec(), ref_alu(2, 8'hCC, 8'hAA));
    end
    ack();
  endtask

  task automatic test_stray_strobes();
    ifc.i_Action = 1'b1;
    tick();
    ifc.i_Action = 1'b0;
    tick();
    n_checks++;
    if (status() !== S_IDLE) begin
      n_errors++; $display("FAIL action_in_collect got=%b exp=%b", status(), S_IDLE);
    end
    arm(5, 8'h0F, 8'h00);
    fire();
    ifc.i_Action = 1'b1;
    tick();
    ifc.i_Action = 1'b0;
    tick();
    n_checks++;
    if (status() !== S_DONE || res_vec() !== ref_alu(5, 8'h0F, 0)) begin
      n_errors++; $display("FAIL action_in_done st=%b res=%h exp=%h", status(), res_vec(), ref_alu(5, 8'h0F, 0));
    end
    ack();
    ack();
    tick();
    n_checks++;
    if (status() !== S_IDLE || res_vec() !== ref_alu(5, 8'h0F, 0)) begin
      n_errors++; $display("FAIL stray_ack st=%b res=%h", status(), res_vec());
    end
  endtask

  task automatic test_shifts();
    arm(6, 8'h81, 8'h00);
    fire();
    n_checks++;
    if (res_vec() !== {8'h02, 1'b0, 1'b1}) begin
      n_errors++; $display("FAIL shl got=%h exp=%h", res_vec(), {8'h02, 1'b0, 1'b1});
    end
    ack();
    arm(7, 8'h81, 8'h00);
    fire();
    n_checks++;
    if (res_vec() !== {8'h40, 1'b0, 1'b1}) begin
      n_errors++; $display("FAIL shr got=%h exp=%h", res_vec(), {8'h40, 1'b0, 1'b1});
    end
    ack();
  endtask

  task automatic test_reset_midop();
    arm(0, 8'h12, 8'h34);
    ifc.i_Action = 1'b1;
    tick();
    ifc.i_Action = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (status() !== S_IDLE || res_vec() !== 10'd0) begin
      n_errors++; $display("FAIL reset_in_exec st=%b res=%h", status(), res_vec());
    end
    tick();
    arm(0, 8'hF0, 8'h20);
    fire();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (status() !== S_IDLE || res_vec() !== 10'd0) begin
      n_errors++; $display("FAIL reset_in_done st=%b res=%h", status(), res_vec());
    end
    tick();
  endtask

  task automatic test_random();
    int op, a, b, mode, gap, wait_n;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 7);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      mode = $urandom_range(0, 2);
      gap = $urandom_range(1, 3);
      wait_n = $urandom_range(0, TMO - 1);
      if (mode == 0) begin
        arm(op, a, b);
      end else begin
        ifc.i_OpValid = (mode == 1); ifc.i_OpCode = op[2:0];
        ifc.i_DataValid = (mode == 2); ifc.i_DataA = a[7:0]; ifc.i_DataB = b[7:0];
        tick();
        ifc.i_OpValid = 1'b0; ifc.i_DataValid = 1'b0;
        for (int g = 1; g < gap; g++) tick();
        ifc.i_OpValid = (mode == 2); ifc.i_DataValid = (mode == 1);
        tick();
        ifc.i_OpValid = 1'b0; ifc.i_DataValid = 1'b0;
      end
      n_checks++;
      if (status() !== S_ARMED) begin
        n_errors++; $display("FAIL rand_armed[%0d] got=%b exp=%b", it, status(), S_ARMED);
      end
      for (int w = 0; w < wait_n; w++) tick();
      fire();
      n_checks++;
      if (status() !== S_DONE || res_vec() !== ref_alu(op, a, b)) begin
        n_errors++; $display("FAIL rand_op[%0d] op=%0d a=%h b=%h st=%b got=%h exp=%h", it, op, a, b, status(), res_vec(), ref_alu(op, a, b));
      end
      ack();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    ifc.i_OpValid = 1'b0; ifc.i_OpCode = 3'd0;
    ifc.i_DataValid = 1'b0; ifc.i_DataA = 8'd0; ifc.i_DataB = 8'd0;
    ifc.i_Action = 1'b0; ifc.i_ResultAck = 1'b0;
    test_reset();
    test_add_same_cycle();
    test_data_first();
    test_timeout();
    test_action_vs_timeout();
    test_stray_strobes();
    test_shifts();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_action_responder.md
Name: alu_action_responder

Overview:
- Operand/opcode staging and execute unit on the consuming side of the ALU action handshake.
- Collects an opcode and an operand pair independently, in either order.
- Advertises readiness on o_ALUOpReady and o_DataReady, waits for the i_Action strobe, then performs a single-cycle ALU operation.
- Holds the result until the downstream acknowledges it. An armed operation that never receives i_Action is abandoned after a bounded wait.

Parameters:
- DATA_WIDTH, 8, operand and result width.
- ACTION_TIMEOUT, 15, maximum cycles spent in ARMED without i_Action before abandoning; must be >= 1.

Ports:
- i_Clk  input  1  clock; all state changes on the rising edge.
- i_Rst_n  input  1  synchronous active-low reset.
- i_OpValid  input  1  opcode offered.
- i_OpCode  input  3  opcode.
- o_OpAccept  output  1  opcode slot free; the transfer happens on an edge where i_OpValid && o_OpAccept.
- i_DataValid  input  1  operand pair offered.
- i_DataA  input  DATA_WIDTH  operand A.
- i_DataB  input  DATA_WIDTH  operand B.
- o_DataAccept  output  1  operand slot free; the transfer happens on an edge where i_DataValid && o_DataAccept.
- o_ALUOpReady  output  1  opcode latched.
- o_DataReady  output  1  operands latched.
- i_Action  input  1  execute strobe; sampled only in ARMED.
- o_Result  output  DATA_WIDTH  registered result.
- o_Zero  output  1  result == 0.
- o_Carry  output  1  carry/borrow/shift-out.
- o_ResultValid  output  1  result held.
- i_ResultAck  input  1  result consumed.
- o_Timeout  output  1  one-cycle pulse when an armed operation is abandoned.

Behaviour:
- Clock and reset: one clock, i_Clk. Reset i_Rst_n is synchronous and active-low. Reset applies at any time, including mid-operation, and discards everything in flight.
- Reset values: state=COLLECT; o_ALUOpReady=0, o_DataReady=0, o_ResultValid=0, o_Timeout=0, o_Result=0, o_Zero=0, o_Carry=0; timeout counter=0.
- States: COLLECT, ARMED, EXEC, DONE.
- Accept signals (combinational from registered state):
  - o_OpAccept = (state==COLLECT) && !o_ALUOpReady.
  - o_DataAccept = (state==COLLECT) && !o_DataReady.
- COLLECT:
  - An accepted opcode is latched and sets o_ALUOpReady on that edge. An accepted operand pair is latched and sets o_DataReady on that edge.
  - Both transfers may occur on the same edge.
  - When both flags are 1 after an edge, the state is ARMED on that same edge and the counter is cleared.
- ARMED:
  - Flags stay high and no new transfers are accepted.
  - If i_Action=1 at an edge: state goes to EXEC and both flags clear on that edge.
  - Otherwise the counter increments. When the counter would reach ACTION_TIMEOUT: flags clear, o_Timeout=1 for exactly the next cycle, and state returns to COLLECT.
  - If i_Action and timeout expiry coincide, i_Action wins.
- i_Action outside ARMED is ignored and has no side effects.
- EXEC (one cycle): at the next edge, o_Result, o_Zero and o_Carry are loaded, o_ResultValid=1, and state goes to DONE. Latency from the i_Action sample edge to o_ResultValid high is 2 edges.
- Opcodes (results truncated to DATA_WIDTH):

  | Code | Operation | Carry |
  |---|---|---|
  | 0 | ADD | carry-out |
  | 1 | SUB, A-B | borrow (A<B) |
  | 2 | AND | 0 |
  | 3 | OR | 0 |
  | 4 | XOR | 0 |
  | 5 | NOT A | 0 |
  | 6 | SHL A by 1 | A[MSB] |
  | 7 | SHR A logical by 1 | A[0] |

- o_Zero = (result == 0) for every opcode.
- DONE:
  - Result outputs are held stable while o_ResultValid=1.
  - An edge with i_ResultAck=1 clears o_ResultValid and returns to COLLECT; new transfers may be accepted on the following edge.
  - i_ResultAck while o_ResultValid=0 is ignored.
  - o_Result, o_Zero and o_Carry keep their last value after ack; they are not cleared.

Test Plan:
- Reset, then opcode 0, A=8'hF0, B=8'h20 offered on the same cycle, then i_Action one cycle after ARMED -> both Ready flags rise together; two edges after Action, o_ResultValid=1, o_Result=8'h10, o_Carry=1, o_Zero=0; held until i_ResultAck.
- Data offered 3 cycles before opcode 1, A=B=8'h55 -> o_DataReady=1 first and o_OpAccept stays 1 meanwhile; after Action, o_Result=0, o_Zero=1, o_Carry=0.
- Armed, i_Action held low -> after ACTION_TIMEOUT (15) cycles in ARMED, both Ready flags go 0, o_Timeout pulses for one cycle, o_ResultValid never rises; the next transfer is accepted.
- i_Action pulsed in COLLECT and in DONE -> no state change, no second result; a second i_ResultAck while o_ResultValid=0 is ignored.
- Opcodes 6 and 7 with A=8'h81 -> SHL gives 8'h02 with carry 1; SHR gives 8'h40 with carry 1.
- i_Rst_n low for one cycle while in EXEC, then while in DONE -> all outputs return to reset values on the next edge and accept signals return high.
